// File: rtl/rll27_stream_encoder.sv
// rll27_stream_encoder: streaming RLL(2,7) encoder with NRZI output.
// Source bits are parsed into RLL(2,7) codewords, NRZI-modulated, buffered,
// and emitted as packed OUT_W-bit words (earliest channel bit in the MSB).
//
// Ports:
//   clk_i        rising-edge clock
//   ari          asynchronous active-high reset
//   in_valid_i   source bit valid
//   in_bit_i     source bit
//   in_ready_o   encoder accepts a source bit this cycle (registered)
//   flush_i      one-cycle pulse: pad the stream out and drain it
//   out_valid_o  out_data_o holds a full word
//   out_ready_i  consumer takes the word
//   out_data_o   NRZI word, earliest channel bit in the MSB
//   out_level_o  NRZI level after the last buffered channel bit
//   busy_o       parser holds a prefix, buffer non-empty, or flush active
//   err_o        sticky run-length violation flag
//
// Optional: define RLL27_RUNLEN_CHECK_EN to build the run-length monitor
// behind err_o; without it err_o is tied low.

module rll27_stream_encoder #(
   parameter int   OUT_W     = 8,
   parameter logic NRZI_INIT = 1'b0
) (
   input  logic             clk_i,
   input  logic             ari,
   input  logic             in_valid_i,
   input  logic             in_bit_i,
   output logic             in_ready_o,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] out_data_o,
   output logic             out_level_o,
   output logic             busy_o,
   output logic             err_o
);

   localparam int CAP = OUT_W + 8;
   localparam int CW  = $clog2(CAP + 1);

   localparam logic [CW-1:0] OW_C  = CW'(OUT_W);
   localparam logic [CW-1:0] LIM_C = CW'(CAP - 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_1,
      S_0,
      S_00,
      S_01,
      S_001
   } st_t;

   st_t              st_q;
   st_t              st_d;
   st_t              st_step;
   logic [CAP-1:0]   buf_q;
   logic [CAP-1:0]   buf_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [CW-1:0]    base;
   logic             lvl_q;
   logic             lvl_d;
   logic             flush_q;
   logic             flush_d;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic [OUT_W-1:0] data_q;

   logic             acc;
   logic             pad_step;
   logic             step;
   logic             step_bit;
   logic             emit;
   logic             push;
   logic             pop;
   logic             bpad;
   logic [7:0]       code;
   logic [3:0]       code_len;
   logic [7:0]       nrz;
   logic             lv;

   // A pad step feeds a source 0 into the parser while a flush is active;
   // it waits for room so a pad codeword can never overflow the buffer.
   assign acc      = in_valid_i & in_ready_q;
   assign pad_step = flush_q & (st_q != S_IDLE) & (cnt_q <= LIM_C);
   assign step     = acc | pad_step;
   assign step_bit = acc & in_bit_i;
   assign push     = step & emit;
   assign pop      = out_valid_q & out_ready_i;

   // Buffer padding only once the parser is empty and the tail is short;
   // out_valid is low then, so no pop can coincide with it.
   assign bpad = flush_q & (st_q == S_IDLE)
               & (cnt_q != '0) & (cnt_q < OW_C);

   // Parser: codewords are left-aligned in code, unused bits zero.
   always_comb begin
      st_step  = st_q;
      emit     = 1'b0;
      code     = 8'h00;
      code_len = 4'd0;
      unique case (st_q)
         S_IDLE: st_step = step_bit ? S_1 : S_0;
         S_1: begin
            emit     = 1'b1;
            code_len = 4'd4;
            code     = step_bit ? 8'b1000_0000 : 8'b0100_0000;
         end
         S_0: st_step = step_bit ? S_01 : S_00;
         S_00: begin
            if (step_bit) begin
               st_step = S_001;
            end else begin
               emit     = 1'b1;
               code_len = 4'd6;
               code     = 8'b0001_0000;
            end
         end
         S_01: begin
            emit     = 1'b1;
            code_len = 4'd6;
            code     = step_bit ? 8'b0010_0000 : 8'b1001_0000;
         end
         S_001: begin
            emit     = 1'b1;
            code_len = 4'd8;
            code     = step_bit ? 8'b0000_1000 : 8'b0010_0100;
         end
         default: st_step = S_IDLE;
      endcase
      if (emit) begin
         st_step = S_IDLE;
      end
   end

   // NRZI: a channel 1 toggles the line. Bits past code_len are zero,
   // so lv ends at the level after the last real channel bit.
   always_comb begin
      lv  = lvl_q;
      nrz = 8'h00;
      for (int i = 0; i < 8; i++) begin
         lv = lv ^ code[7-i];
         if (4'(i) < code_len) begin
            nrz[7-i] = lv;
         end
      end
   end

   // Buffer is left-aligned: bit CAP-1 is the oldest channel bit and
   // everything below cnt is kept zero so a push can simply OR in.
   always_comb begin
      buf_d = buf_q;
      lvl_d = lvl_q;
      base  = cnt_q;
      if (pop) begin
         buf_d = buf_q << OUT_W;
         base  = cnt_q - OW_C;
      end
      if (push) begin
         buf_d = buf_d | ({nrz, {OUT_W{1'b0}}} >> base);
         lvl_d = lv;
      end
      if (bpad) begin
         for (int i = 0; i < OUT_W; i++) begin
            if (CW'(i) >= cnt_q) begin
               buf_d[CAP-1-i] = lvl_q;
            end
         end
      end
      cnt_d = base + (push ? CW'(code_len) : '0);
      if (bpad) begin
         cnt_d = OW_C;
      end
   end

   always_comb begin
      st_d    = step ? st_step : st_q;
      flush_d = flush_q;
      if (!flush_q && flush_i) begin
         flush_d = 1'b1;
      end else if (flush_q && st_d == S_IDLE && cnt_d == '0) begin
         flush_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge ari) begin
      if (ari) begin
         st_q        <= S_IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         lvl_q       <= NRZI_INIT;
         flush_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         data_q      <= '0;
      end else begin
         st_q        <= st_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         lvl_q       <= lvl_d;
         flush_q     <= flush_d;
         in_ready_q  <= !flush_d && (cnt_d <= LIM_C);
         out_valid_q <= cnt_d >= OW_C;
         busy_q      <= flush_d || (st_d != S_IDLE) || (cnt_d != '0);
         data_q      <= buf_d[CAP-1 -: OUT_W];
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = data_q;
   assign out_level_o = lvl_q;
   assign busy_o      = busy_q;

`ifdef RLL27_RUNLEN_CHECK_EN
   logic [3:0] zr_q;
   logic [3:0] zr_d;
   logic       seen_q;
   logic       seen_d;
   logic       err_q;
   logic       err_d;

   // Runs are counted on channel bits of real codewords only; anything
   // pushed during a flush is pad and restarts the run tracking.
   always_comb begin
      zr_d   = zr_q;
      seen_d = seen_q;
      err_d  = err_q;
      if (flush_q) begin
         zr_d   = '0;
         seen_d = 1'b0;
      end else if (push) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) < code_len) begin
               if (code[7-i]) begin
                  if (seen_d && zr_d < 4'd2) begin
                     err_d = 1'b1;
                  end
                  zr_d   = '0;
                  seen_d = 1'b1;
               end else begin
                  if (zr_d != 4'd15) begin
                     zr_d = zr_d + 4'd1;
                  end
                  if (seen_d && zr_d > 4'd7) begin
                     err_d = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge ari) begin
      if (ari) begin
         zr_q   <= '0;
         seen_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         zr_q   <= zr_d;
         seen_q <= seen_d;
         err_q  <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
